decode: RTL and testbench
=========================

Name: decode

Overview:
Second stage of the pipelined processor, directly downstream of fetch. It consumes the PC and the instruction word read from main memory. It decodes a MIPS-I integer subset, reads the 32x32 register file (write port driven by writeback), and registers operands, immediate and control into the ID/EX latch. It detects load-use hazards and stalls fetch.

Parameters:
- RESET_PC, 32'h80020000, value loaded into pc_out on reset.
- REG_COUNT, 32, number of architectural registers; r0 is hardwired to zero.

Ports:
- clk_in  input  1  stage clock (posedge)
- rst_in  input  1  asynchronous reset, active-high
- pc_in  input  32  PC of the instruction presented (from fetch pc_out)
- insn_in  input  32  instruction word from main memory data_out
- insn_valid_in  input  1  insn_in/pc_in are a real instruction
- stall_in  input  1  downstream stall; hold ID/EX latch
- wb_en_in  input  1  register-file write enable from writeback
- wb_addr_in  input  5  writeback destination register
- wb_data_in  input  32  writeback data
- stall_out  output  1  to fetch stall_in; combinational
- valid_out  output  1  ID/EX latch holds a real instruction
- pc_out  output  32  latched PC
- insn_out  output  32  latched instruction
- rs_data_out  output  32  rs operand
- rt_data_out  output  32  rt operand
- imm_out  output  32  extended immediate
- shamt_out  output  5  shift amount
- dest_reg_out  output  5  destination register
- alu_op_out  output  4  ALU operation encoding
- reg_write_out, mem_read_out, mem_write_out, alu_src_imm_out, branch_out, branch_ne_out, jump_out, jump_reg_out, link_out  output  1 each  control
- illegal_out  output  1  unrecognised opcode/funct

Behaviour:
- Reset (async, rst_in high): all ID/EX outputs 0, pc_out=RESET_PC, valid_out=0, and all registers in the register file 0. The release of reset is synchronous to clk_in.
- Latency: one cycle from insn_in to the ID/EX outputs. stall_out is combinational in the same cycle.
- Register file:
  - Write at posedge when wb_en_in=1 and wb_addr_in!=0. Writes to r0 are ignored.
  - Read is combinational with write-through bypass: if wb_en_in and wb_addr_in==rs (or rt) and the address is !=0, the read returns wb_data_in.
  - Writeback proceeds even while stalled.
- Load-use hazard: hazard = valid_out & mem_read_out & (dest_reg_out!=0) & insn_valid_in & (dest_reg_out==rs | (dest_reg_out==rt & the instruction reads rt)).
  - "Reads rt" applies to R-type, SW, BEQ and BNE.
- stall_out = stall_in | hazard.
- Priority at posedge (exactly one applies):
  - stall_in=1: hold all outputs.
  - else hazard or !insn_valid_in: load a bubble. valid_out=0 and all control outputs 0; data fields are don't-care but driven 0.
  - else: latch the decoded instruction with valid_out=1.
- Immediates:
  - Sign-extend for ADDIU, SLTI, LW, SW, BEQ and BNE.
  - Zero-extend for ANDI, ORI and XORI.
  - LUI gives {imm16,16'h0}.
  - J/JAL give {4'h0,target26,2'b00}; the upper bits are merged downstream.
- Destination register: rd for R-type, rt for I-type, 31 for JAL.
- alu_op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 LUI.
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, SLT, SLL, SRL, SRA, JR.
  - I-type: ADDIU, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - Jumps: J, JAL.
- SLL with all-zero insn (NOP): reg_write_out=1 and dest=0, which is harmless.
- Control per class:
  - LW: mem_read=1, reg_write=1, alu_src_imm=1, ADD.
  - SW: mem_write=1, alu_src_imm=1, ADD.
  - BEQ/BNE: branch=1, SUB; BNE also sets branch_ne=1.
  - JR: jump_reg=1.
  - JAL: jump=1, link=1, reg_write=1.
- Illegal opcode or funct: illegal_out=1, valid_out=1, and all other controls 0 (treated as NOP).

Test Plan:
- Reset mid-operation, then release; present 0x2408FFFC (ADDIU $8,$0,-4) -> next cycle valid_out=1, dest_reg_out=8, imm_out=0xFFFFFFFC, alu_src_imm_out=1, reg_write_out=1, alu_op_out=0, rs_data_out=0.
- Present ORI 0x35088000 -> imm_out=0x00008000, alu_op_out=3. Present LUI 0x3C011234 -> imm_out=0x12340000, alu_op_out=9, dest=1.
- Present LW 0x8D090000 then ADDU 0x01285021 -> stall_out=1 for exactly one cycle, followed by a bubble (valid_out=0). Then ADDU latches with rs=9, rt=8, dest=10 and stall_out=0.
- Hold wb_en_in=1, wb_addr_in=8, wb_data_in=0xDEADBEEF in the same cycle as ADDU reads $8 -> rt_data_out=0xDEADBEEF. Writeback to r0 with 0x1234 followed by a read of $0 -> 0.
- Assert stall_in for 3 cycles while insn_in changes -> outputs unchanged and stall_out=1. Present JAL 0x0C000010 -> jump_out=1, link_out=1, dest_reg_out=31, imm_out=0x00000040.
- Present opcode 0x3F -> illegal_out=1, reg_write_out=0, mem_write_out=0.

Source files
------------

// File: rtl/decode.sv
// Decode stage: MIPS-I subset decoder, 32x32 register file with write-through
// bypass, ID/EX pipeline latch and load-use hazard detection.
module decode #(
  parameter logic [31:0] RESET_PC  = 32'h80020000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] insn_in,
  input  logic        insn_valid_in,
  input  logic        stall_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic [31:0] rs_data_out,
  output logic [31:0] rt_data_out,
  output logic [31:0] imm_out,
  output logic [4:0]  shamt_out,
  output logic [4:0]  dest_reg_out,
  output logic [3:0]  alu_op_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        alu_src_imm_out,
  output logic        branch_out,
  output logic        branch_ne_out,
  output logic        jump_out,
  output logic        jump_reg_out,
  output logic        link_out,
  output logic        illegal_out
);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
                         F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_SLT = 6'h2A;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7,
                         A_SRA = 4'd8, A_LUI = 4'd9;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_imm;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic        link;
    logic        illegal;
  } idex_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_se, imm_ze;
  logic [31:0] rf_q [REG_COUNT];
  logic [31:0] rs_val, rt_val;
  logic        reads_rt, hazard;
  idex_t       dec, idex_d, idex_q;

  assign op     = insn_in[31:26];
  assign rs     = insn_in[25:21];
  assign rt     = insn_in[20:16];
  assign rd     = insn_in[15:11];
  assign funct  = insn_in[5:0];
  assign imm_se = {{16{insn_in[15]}}, insn_in[15:0]};
  assign imm_ze = {16'h0, insn_in[15:0]};

  // Writeback is independent of any stall; r0 is never written so it reads 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_en_in && wb_addr_in != 5'd0) begin
      rf_q[wb_addr_in] <= wb_data_in;
    end
  end

  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (wb_en_in && wb_addr_in != 5'd0 && wb_addr_in == rs) rs_val = wb_data_in;
    if (wb_en_in && wb_addr_in != 5'd0 && wb_addr_in == rt) rt_val = wb_data_in;
  end

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.pc      = pc_in;
    dec.insn    = insn_in;
    dec.rs_data = rs_val;
    dec.rt_data = rt_val;
    dec.shamt   = insn_in[10:6];
    case (op)
      OP_R: begin
        dec.dest      = rd;
        dec.reg_write = 1'b1;
        case (funct)
          F_ADDU: dec.alu_op = A_ADD;
          F_SUBU: dec.alu_op = A_SUB;
          F_AND:  dec.alu_op = A_AND;
          F_OR:   dec.alu_op = A_OR;
          F_XOR:  dec.alu_op = A_XOR;
          F_SLT:  dec.alu_op = A_SLT;
          F_SLL:  dec.alu_op = A_SLL;
          F_SRL:  dec.alu_op = A_SRL;
          F_SRA:  dec.alu_op = A_SRA;
          F_JR: begin
            dec.dest      = '0;
            dec.reg_write = 1'b0;
            dec.jump_reg  = 1'b1;
          end
          default: begin
            dec.dest      = '0;
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        dec.dest        = rt;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_se;
        case (op)
          OP_SLTI: dec.alu_op = A_SLT;
          OP_ANDI: begin dec.alu_op = A_AND; dec.imm = imm_ze; end
          OP_ORI:  begin dec.alu_op = A_OR;  dec.imm = imm_ze; end
          OP_XORI: begin dec.alu_op = A_XOR; dec.imm = imm_ze; end
          OP_LUI:  begin dec.alu_op = A_LUI; dec.imm = {insn_in[15:0], 16'h0}; end
          OP_LW:   dec.mem_read = 1'b1;
          default: dec.alu_op = A_ADD;
        endcase
      end
      OP_SW: begin
        dec.dest        = rt;
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = imm_se;
      end
      OP_BEQ, OP_BNE: begin
        dec.dest      = rt;
        dec.branch    = 1'b1;
        dec.branch_ne = (op == OP_BNE);
        dec.alu_op    = A_SUB;
        dec.imm       = imm_se;
      end
      OP_J, OP_JAL: begin
        // Upper PC bits are merged downstream.
        dec.jump      = 1'b1;
        dec.imm       = {4'h0, insn_in[25:0], 2'b00};
        dec.link      = (op == OP_JAL);
        dec.reg_write = (op == OP_JAL);
        dec.dest      = (op == OP_JAL) ? 5'd31 : 5'd0;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign reads_rt  = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign hazard    = idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0) && insn_valid_in &&
                     ((idex_q.dest == rs) || (idex_q.dest == rt && reads_rt));
  assign stall_out = stall_in || hazard;

  always_comb begin
    idex_d = dec;
    if (stall_in)                        idex_d = idex_q;
    else if (hazard || !insn_valid_in)   idex_d = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idex_q    <= '0;
      idex_q.pc <= RESET_PC;
    end else begin
      idex_q    <= idex_d;
    end
  end

  assign valid_out       = idex_q.valid;
  assign pc_out          = idex_q.pc;
  assign insn_out        = idex_q.insn;
  assign rs_data_out     = idex_q.rs_data;
  assign rt_data_out     = idex_q.rt_data;
  assign imm_out         = idex_q.imm;
  assign shamt_out       = idex_q.shamt;
  assign dest_reg_out    = idex_q.dest;
  assign alu_op_out      = idex_q.alu_op;
  assign reg_write_out   = idex_q.reg_write;
  assign mem_read_out    = idex_q.mem_read;
  assign mem_write_out   = idex_q.mem_write;
  assign alu_src_imm_out = idex_q.alu_src_imm;
  assign branch_out      = idex_q.branch;
  assign branch_ne_out   = idex_q.branch_ne;
  assign jump_out        = idex_q.jump;
  assign jump_reg_out    = idex_q.jump_reg;
  assign link_out        = idex_q.link;
  assign illegal_out     = idex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: constant vector table, hand-written hazard/bypass/stall
// sequences, and randomized traffic against a mnemonic-level reference model.
module tb_decode;
  localparam logic [31:0] RST_PC = 32'h80020000;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_i = '0, insn_i = '0, wb_data_i = '0;
  logic        iv_i = 1'b0, st_i = 1'b0, wb_en_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic        stall_o, valid_o, rw_o, mr_o, mw_o, asi_o, br_o, bne_o, j_o, jr_o, lnk_o, ill_o;
  logic [31:0] pc_o, insn_o, rsd_o, rtd_o, imm_o;
  logic [4:0]  shamt_o, dest_o;
  logic [3:0]  alu_o;

  decode dut (
    .clk_in(clk), .rst_in(rst), .pc_in(pc_i), .insn_in(insn_i), .insn_valid_in(iv_i),
    .stall_in(st_i), .wb_en_in(wb_en_i), .wb_addr_in(wb_addr_i), .wb_data_in(wb_data_i),
    .stall_out(stall_o), .valid_out(valid_o), .pc_out(pc_o), .insn_out(insn_o),
    .rs_data_out(rsd_o), .rt_data_out(rtd_o), .imm_out(imm_o), .shamt_out(shamt_o),
    .dest_reg_out(dest_o), .alu_op_out(alu_o), .reg_write_out(rw_o), .mem_read_out(mr_o),
    .mem_write_out(mw_o), .alu_src_imm_out(asi_o), .branch_out(br_o), .branch_ne_out(bne_o),
    .jump_out(j_o), .jump_reg_out(jr_o), .link_out(lnk_o), .illegal_out(ill_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, insn, rs, rt, imm;
    logic [4:0]  shamt, dest;
    logic [3:0]  alu;
    logic [9:0]  ctrl;  // rw mr mw asi br bne j jr lnk ill
  } out_t;

  typedef struct {
    logic [31:0] insn, imm;
    logic [3:0]  alu;
    logic [4:0]  dest, shamt;
    logic [9:0]  ctrl;
  } vec_t;

  typedef enum {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_SRA, M_JR,
                M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
                M_J, M_JAL, M_ILL} mn_t;

  int          total = 0, bad = 0;
  logic [31:0] mrf [32];
  out_t        exp_q;
  vec_t        tbl [10];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = {valid_o, pc_o, insn_o, rsd_o, rtd_o, imm_o, shamt_o, dest_o, alu_o,
         {rw_o, mr_o, mw_o, asi_o, br_o, bne_o, j_o, jr_o, lnk_o, ill_o}};
    return o;
  endfunction

  function automatic mn_t classify(input logic [31:0] i);
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h21: return M_ADDU; 6'h23: return M_SUBU; 6'h24: return M_AND;
        6'h25: return M_OR;   6'h26: return M_XOR;  6'h2A: return M_SLT;
        6'h00: return M_SLL;  6'h02: return M_SRL;  6'h03: return M_SRA;
        6'h08: return M_JR;   default: return M_ILL;
      endcase
      6'h09: return M_ADDIU; 6'h0A: return M_SLTI; 6'h0C: return M_ANDI;
      6'h0D: return M_ORI;   6'h0E: return M_XORI; 6'h0F: return M_LUI;
      6'h23: return M_LW;    6'h2B: return M_SW;   6'h04: return M_BEQ;
      6'h05: return M_BNE;   6'h02: return M_J;    6'h03: return M_JAL;
      default: return M_ILL;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (wb_en_i && wb_addr_i != 0 && wb_addr_i == a) return wb_data_i;
    return mrf[a];
  endfunction

  // Reference: ALU op index is the position in the spec's ADD..LUI list.
  function automatic out_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    out_t  o;
    mn_t   m;
    int    se, ze;
    m  = classify(i);
    se = int'($signed(i[15:0]));
    ze = int'(i[15:0]);
    o = '0;
    o.valid = 1; o.pc = pc; o.insn = i; o.shamt = i[10:6];
    o.rs = rd_model(i[25:21]); o.rt = rd_model(i[20:16]);
    if (m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_SRA}) begin
      o.ctrl[9] = 1; o.dest = i[15:11];
      o.alu = (m == M_ADDU) ? 0 : (m == M_SUBU) ? 1 : (m == M_AND) ? 2 : (m == M_OR) ? 3 :
              (m == M_XOR) ? 4 : (m == M_SLT) ? 5 : (m == M_SLL) ? 6 : (m == M_SRL) ? 7 : 8;
    end else if (m inside {M_ADDIU, M_SLTI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW}) begin
      o.ctrl[9] = 1; o.ctrl[6] = 1; o.dest = i[20:16];
      o.ctrl[8] = (m == M_LW);
      o.alu = (m == M_SLTI) ? 5 : (m == M_ANDI) ? 2 : (m == M_ORI) ? 3 : (m == M_XORI) ? 4 :
              (m == M_LUI) ? 9 : 0;
      o.imm = (m == M_LUI) ? (ze * 65536) : (m inside {M_ANDI, M_ORI, M_XORI}) ? ze : se;
    end else if (m == M_SW) begin
      o.ctrl[7] = 1; o.ctrl[6] = 1; o.dest = i[20:16]; o.imm = se;
    end else if (m == M_BEQ || m == M_BNE) begin
      o.ctrl[5] = 1; o.ctrl[4] = (m == M_BNE); o.alu = 1; o.dest = i[20:16]; o.imm = se;
    end else if (m == M_J || m == M_JAL) begin
      o.ctrl[3] = 1; o.imm = i[25:0] * 4;
      if (m == M_JAL) begin o.ctrl[9] = 1; o.ctrl[1] = 1; o.dest = 31; end
    end else if (m == M_JR) begin
      o.ctrl[2] = 1;
    end else begin
      o.ctrl[0] = 1;
    end
    return o;
  endfunction

  function automatic out_t reset_val();
    out_t o;
    o = '0;
    o.pc = RST_PC;
    return o;
  endfunction

  // One clock: drive inputs, check combinational stall, advance the model, check the latch.
  task automatic cycle(input logic [31:0] insn, input logic iv, input logic st,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    logic reads_rt, hz;
    mn_t  m;
    out_t nxt;
    insn_i = insn; iv_i = iv; st_i = st; wb_en_i = wbe; wb_addr_i = wba; wb_data_i = wbd;
    pc_i = pc_i + 4;
    #1;
    m = classify(insn);
    reads_rt = (insn[31:26] == 6'h00) || m == M_SW || m == M_BEQ || m == M_BNE;
    hz = exp_q.valid && exp_q.ctrl[8] && exp_q.dest != 0 && iv &&
         (exp_q.dest == insn[25:21] || (exp_q.dest == insn[20:16] && reads_rt));
    chk("stall_out", 256'(stall_o), 256'(st | hz));
    if (st)            nxt = exp_q;
    else if (hz || !iv) nxt = '0;
    else               nxt = ref_decode(insn, pc_i);
    @(posedge clk);
    if (wbe && wba != 0) mrf[wba] = wbd;
    exp_q = nxt;
    #1;
    chk("idex", 256'(dut_out()), 256'(exp_q));
  endtask

  function automatic logic [31:0] rand_insn();
    logic [5:0] op, fn;
    logic [31:0] i;
    case ($urandom_range(0, 16))
      0, 1, 2: op = 6'h00; 3: op = 6'h09; 4: op = 6'h0A; 5: op = 6'h0C; 6: op = 6'h0D;
      7: op = 6'h0E; 8: op = 6'h0F; 9, 10, 11: op = 6'h23; 12: op = 6'h2B;
      13: op = 6'h04; 14: op = 6'h05; 15: op = ($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03;
      default: op = 6'h3F;
    endcase
    case ($urandom_range(0, 10))
      0: fn = 6'h21; 1: fn = 6'h23; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h26; 5: fn = 6'h2A;
      6: fn = 6'h00; 7: fn = 6'h02; 8: fn = 6'h03; 9: fn = 6'h08; default: fn = 6'h01;
    endcase
    i = $urandom;
    i[31:26] = op;
    if (op != 6'h02 && op != 6'h03) begin
      i[25:21] = 5'($urandom_range(0, 7));
      i[20:16] = 5'($urandom_range(0, 7));
      if (op == 6'h00) begin i[15:11] = 5'($urandom_range(0, 7)); i[5:0] = fn; end
    end
    return i;
  endfunction

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++)
      cycle(rand_insn(), $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic model_reset();
    exp_q = reset_val();
    for (int k = 0; k < 32; k++) mrf[k] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h2408FFFC, 32'hFFFFFFFC, 4'd0, 5'd8,  5'h1F, 10'b1001000000}; // ADDIU
    tbl[1] = '{32'h35088000, 32'h00008000, 4'd3, 5'd8,  5'h00, 10'b1001000000}; // ORI
    tbl[2] = '{32'h3C011234, 32'h12340000, 4'd9, 5'd1,  5'h08, 10'b1001000000}; // LUI
    tbl[3] = '{32'h0C000010, 32'h00000040, 4'd0, 5'd31, 5'h00, 10'b1000001010}; // JAL
    tbl[4] = '{32'hFC000000, 32'h00000000, 4'd0, 5'd0,  5'h00, 10'b0000000001}; // illegal op
    tbl[5] = '{32'hAD090004, 32'h00000004, 4'd0, 5'd9,  5'h00, 10'b0011000000}; // SW
    tbl[6] = '{32'h1509FFFF, 32'hFFFFFFFF, 4'd1, 5'd9,  5'h1F, 10'b0000110000}; // BNE
    tbl[7] = '{32'h01000008, 32'h00000000, 4'd0, 5'd0,  5'h00, 10'b0000000100}; // JR
    tbl[8] = '{32'h00000000, 32'h00000000, 4'd6, 5'd0,  5'h00, 10'b1000000000}; // NOP
    tbl[9] = '{32'h00084083, 32'h00000000, 4'd8, 5'd8,  5'h02, 10'b1000000000}; // SRA

    rst = 1'b1;
    model_reset();
    #1;
    chk("reset_state", 256'(dut_out()), 256'(reset_val()));
    @(posedge clk); #1; rst = 1'b0;
    random_cycles(30);

    // Asynchronous reset mid-operation, between clock edges.
    #2; rst = 1'b1; #1;
    model_reset();
    chk("async_reset", 256'(dut_out()), 256'(reset_val()));
    @(posedge clk); #1; rst = 1'b0;
    chk("reset_hold", 256'(dut_out()), 256'(reset_val()));

    for (int k = 0; k < 10; k++) begin
      cycle(tbl[k].insn, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("tbl%0d_valid", k), 256'(valid_o), 256'(1'b1));
      chk($sformatf("tbl%0d_imm", k), 256'(imm_o), 256'(tbl[k].imm));
      chk($sformatf("tbl%0d_alu", k), 256'(alu_o), 256'(tbl[k].alu));
      chk($sformatf("tbl%0d_dest", k), 256'(dest_o), 256'(tbl[k].dest));
      chk($sformatf("tbl%0d_shamt", k), 256'(shamt_o), 256'(tbl[k].shamt));
      chk($sformatf("tbl%0d_ctrl", k), 256'({rw_o, mr_o, mw_o, asi_o, br_o, bne_o, j_o, jr_o, lnk_o, ill_o}),
          256'(tbl[k].ctrl));
      chk($sformatf("tbl%0d_rs", k), 256'(rsd_o), 256'(0));
    end

    // Load-use: LW $9 then ADDU $10,$9,$8 -> one stall cycle and a bubble.
    cycle(32'h8D090000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lw_memread", 256'(mr_o), 256'(1'b1));
    cycle(32'h01285021, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("bubble_valid", 256'(valid_o), 256'(1'b0));
    // Same cycle writeback to $8 must bypass into rt.
    cycle(32'h01285021, 1'b1, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
    chk("addu_valid", 256'(valid_o), 256'(1'b1));
    chk("addu_dest", 256'(dest_o), 256'(10));
    chk("bypass_rt", 256'(rtd_o), 256'(32'hDEADBEEF));
    chk("addu_nostall", 256'(stall_o), 256'(1'b0));
    // Writes to r0 are ignored, including the bypass path.
    cycle(32'h00005021, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
    chk("r0_bypass", 256'(rsd_o), 256'(0));
    cycle(32'h00005021, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("r0_read", 256'(rsd_o), 256'(0));

    // Downstream stall holds the latch while the input keeps changing.
    cycle(32'h35088000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(32'h24000000 + k, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      chk("stall_hold_imm", 256'(imm_o), 256'(32'h00008000));
    end
    cycle(32'h0C000010, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("jal_link", 256'({j_o, lnk_o, dest_o}), 256'({1'b1, 1'b1, 5'd31}));
    cycle(32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("ill_flags", 256'({ill_o, rw_o, mw_o, valid_o}), 256'(4'b1001));

    random_cycles(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
